// File: rtl/uart_pkg.sv
// UART types and framing constants shared by the transmitter and receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP
    } tx_state_t;

    localparam int DATA_BITS      = 8;
    localparam int BYTES_PER_WORD = 2;
    localparam int FRAME_BITS     = 10;

endpackage

// File: rtl/uart_tx_byte.sv
// Serializes one byte as an 8N1 frame; owns the bit timer and START/DATA/STOP sequencing.
// Latency: line drops on the edge that samples start; frame lasts FRAME_BITS*CLKS_PER_BIT cycles.
// Backpressure: start is only legal while idle or on the cycle done is high (back-to-back chaining).
module uart_tx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_dat,
    input  logic       start,
    output logic       done,
    output logic       ser_out
);

    localparam int            TW       = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LOAD = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_byte: CLKS_PER_BIT must be >= 2");
    end

    tx_state_t     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    byte_q, byte_d;
    logic          ser_q, ser_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            byte_q    <= '0;
            ser_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            byte_q    <= byte_d;
            ser_q     <= ser_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        byte_d    = byte_q;
        ser_d     = ser_q;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                ser_d = 1'b1;
                if (start) begin
                    state_d = START;
                    timer_d = BIT_LOAD;
                    byte_d  = byte_dat;
                    ser_d   = 1'b0;
                end
            end
            START: begin
                if (timer_q == '0) begin
                    state_d   = DATA;
                    timer_d   = BIT_LOAD;
                    bit_idx_d = '0;
                    ser_d     = byte_q[0];
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            DATA: begin
                if (timer_q == '0) begin
                    timer_d = BIT_LOAD;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                        ser_d   = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        ser_d     = byte_q[bit_idx_q + 3'd1];
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            STOP: begin
                if (timer_q == '0) begin
                    done = 1'b1;
                    // A start on the final stop cycle chains straight into the next start bit.
                    if (start) begin
                        state_d = START;
                        timer_d = BIT_LOAD;
                        byte_d  = byte_dat;
                        ser_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        ser_d   = 1'b1;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                ser_d   = 1'b1;
            end
        endcase
    end

    assign ser_out = ser_q;

endmodule

// File: rtl/uart_tx_word.sv
// Accepts a 16-bit word on valid/ready and sends it as two 8N1 frames, low byte first, plus optional idle gap.
// Latency: start bit begins the cycle after accept; word occupies 20*CLKS_PER_BIT (+gap) cycles.
// Backpressure: data_send_ready only while idle and out of reset; one idle cycle between words.
module uart_tx_word
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int IDLE_BITS    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_send,
    input  logic        data_send_valid,
    output logic        data_send_ready,
    output logic        ser_out,
    output logic        busy
);

    localparam int            GAP_CYCLES = (IDLE_BITS > 0) ? IDLE_BITS * CLKS_PER_BIT : 1;
    localparam int            GW         = $clog2(GAP_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES - 1);
    localparam logic          LAST_BYTE  = 1'(BYTES_PER_WORD - 1);

    tx_state_t     state_q, state_d;
    logic [15:0]   word_q, word_d;
    logic          byte_idx_q, byte_idx_d;
    logic [GW-1:0] gap_q, gap_d;

    logic          accept;
    logic          byte_start;
    logic          byte_done;
    logic [7:0]    byte_dat;

    assign data_send_ready = (state_q == IDLE) && !rst;
    assign accept          = data_send_valid && data_send_ready;
    assign busy            = (state_q != IDLE) && !rst;

    // Byte 0 goes straight from the input bus so the start bit can begin on the accept edge.
    assign byte_start = accept || (byte_done && (byte_idx_q != LAST_BYTE));
    assign byte_dat   = accept ? data_send[7:0] : word_q[{byte_idx_q + 1'b1, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            word_q     <= '0;
            byte_idx_q <= 1'b0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
            gap_q      <= gap_d;
        end
    end

    // DATA here stands for the whole two-frame body, which the byte engine sequences.
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        gap_d      = gap_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = DATA;
                    word_d     = data_send;
                    byte_idx_d = 1'b0;
                end
            end
            DATA: begin
                if (byte_done) begin
                    if (byte_idx_q != LAST_BYTE) begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end else begin
                        byte_idx_d = 1'b0;
                        if (IDLE_BITS > 0) begin
                            state_d = GAP;
                            gap_d   = GAP_LOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk     (clk),
        .rst     (rst),
        .byte_dat(byte_dat),
        .start   (byte_start),
        .done    (byte_done),
        .ser_out (ser_out)
    );

endmodule
